// File: rtl/des_scan_capture.sv
// Deserializes the DES scan-out stream into 16 committed round words.
// A capture starts on a TestMode rise and commits only when all bits arrive.
module des_scan_capture #(
  parameter int NBITS  = 512,
  parameter int WORD   = 32,
  parameter int NWORDS = 16,
  parameter int LEAD   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            TestMode,
  input  logic            SOUT,
  input  logic            ack,
  input  logic [3:0]      rd_sel,
  output logic [WORD-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic            abort_err,
  output logic [9:0]      bit_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LEAD_WAIT,
    SHIFT,
    DONE
  } state_t;

  localparam logic [9:0] LAST   = 10'(NBITS - 1);
  localparam logic [3:0] LEAD_N = 4'(LEAD);
  localparam logic [3:0] TOP_W  = 4'(NWORDS - 1);

  state_t state_q, state_d;

  logic                         tm_q;
  logic                         rise;
  logic [3:0]                   lead_cnt;
  logic [NBITS-1:0]             sh;
  logic [NWORDS-1:0][WORD-1:0]  cw;

  logic clr, take, commit, abort, lead_inc;

  assign rise = TestMode & ~tm_q;

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    take     = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    lead_inc = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          clr = 1'b1;
          if (LEAD_N == 4'd0) begin
            take    = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = LEAD_WAIT;
          end
        end
      end
      LEAD_WAIT: begin
        if (!TestMode) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (lead_cnt == LEAD_N) begin
          // the skipped cycles include the rise edge itself
          take    = 1'b1;
          state_d = SHIFT;
        end else begin
          lead_inc = 1'b1;
        end
      end
      SHIFT: begin
        if (!TestMode) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          take = 1'b1;
          if (bit_cnt == LAST) begin
            commit  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tm_q      <= 1'b0;
      lead_cnt  <= '0;
      sh        <= '0;
      cw        <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      state_q <= state_d;
      tm_q    <= TestMode;
      if (clr) begin
        lead_cnt <= 4'd1;
        sh       <= take ? {{(NBITS-1){1'b0}}, SOUT} : '0;
        bit_cnt  <= take ? 10'd1 : 10'd0;
      end else if (take) begin
        sh      <= {sh[NBITS-2:0], SOUT};
        bit_cnt <= bit_cnt + 10'd1;
      end else if (lead_inc) begin
        lead_cnt <= lead_cnt + 4'd1;
      end
      if (commit) begin
        cw <= {sh[NBITS-2:0], SOUT};
      end
      if (commit) begin
        done <= 1'b1;
      end else if (ack) begin
        done <= 1'b0;
      end
      if (clr) begin
        abort_err <= 1'b0;
      end else if (abort) begin
        abort_err <= 1'b1;
      end
    end
  end

  assign busy    = (state_q == LEAD_WAIT) || (state_q == SHIFT);
  assign rd_data = cw[TOP_W - rd_sel];

endmodule

// File: doc/des_scan_capture.md
Name: des_scan_capture

Overview:
Serial-to-parallel receiver for the DES core's scan-out port. While DES runs in TestMode it shifts its 512-bit round-register chain out on SOUT, one bit per clk. This block deserializes that stream and rebuilds the 16 32-bit round outputs (R1..R16), so on-chip checkers or a host can read any round without the wide ScanOut bus. It sits beside DES and is driven by the same TestMode and clk.

Parameters:
NBITS, 512, scan chain length in bits (must equal NWORDS*WORD).
WORD, 32, round word width.
NWORDS, 16, number of round words.
LEAD, 0, clk cycles skipped after TestMode is sampled high before the first SOUT bit is taken (0..15).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
TestMode  in  1  scan enable shared with DES; rising edge starts a capture.
SOUT  in  1  serial scan data from DES.
ack  in  1  host acknowledge; clears done.
rd_sel  in  4  round select, 0 = R1 ... 15 = R16.
rd_data  out  32  committed round word selected by rd_sel.
busy  out  1  high while skipping or shifting.
done  out  1  high from capture completion until acknowledged.
abort_err  out  1  sticky; set when TestMode falls mid-capture.
bit_cnt  out  10  number of bits shifted in the current capture.

Behaviour:
- Reset (async, rst_n=0): state IDLE; shift register, committed array, bit_cnt, lead counter = 0; busy=0, done=0, abort_err=0, rd_data=0.
- Storage: 512-bit shift register plus 512-bit committed array. rd_data is combinational from the committed array. The committed array changes only on a complete capture.
- Bit order: the first captured bit is ScanOut[512]. After 512 bits, round Rn (n=1..16) occupies chain bits [NBITS-32n+1 : NBITS-32(n-1)]. R1 is bits [481:512]; R16 is bits [1:32]. Within a word, the first received bit is the MSB.
- TestMode rise: a registered copy of TestMode is kept. Rise = TestMode=1 and the registered copy = 0.
- FSM:
  - IDLE: on rise, go to LEAD_WAIT if LEAD>0, else SHIFT; clear bit_cnt and the shift register.
  - LEAD_WAIT: count LEAD cycles with SOUT ignored, then go to SHIFT.
  - SHIFT: each cycle, shift SOUT in at the LSB end and increment bit_cnt. When the 512th bit is taken, copy the shift register (including that bit) to the committed array in the same edge, set done, and go to DONE.
  - DONE: done=1, busy=0. A new rise here restarts the capture; done stays high until ack.
- Timing: with LEAD=0, the bit present on SOUT at the edge where the rise is first sampled is bit 1. done asserts at the edge that takes bit 512, i.e. 511 cycles later.
- busy=1 in LEAD_WAIT and SHIFT only.
- ack: clears done on the next edge in any state. ack has no effect in IDLE or SHIFT beyond clearing done.
- Abort: TestMode=0 in LEAD_WAIT or SHIFT sets abort_err and returns to IDLE. The committed array is untouched. bit_cnt holds the partial count until the next rise.
- abort_err clears only on a new rise or on reset.
- Simultaneous events:
  - ack at the completion edge: done ends set (completion wins).
  - Rise while done=1: done stays set until ack.
- TestMode held high after completion does not retrigger; only a fresh rise does.

Test Plan:
- Full capture, LEAD=0: drive a 512-bit stream where word n = 32'hA5000000+n (n=1..16), R1 first, MSB first. Then done=1 exactly 511 cycles after the rise; rd_sel=0 gives A5000001; rd_sel=15 gives A5000010; bit_cnt=512.
- Abort: drop TestMode after 100 bits. Then abort_err=1, busy=0, bit_cnt=100, state IDLE; rd_data still shows the previous capture. The next rise clears abort_err.
- Reset mid-shift: assert rst_n=0 at bit 300 (asynchronously, between edges). All outputs go 0 immediately; the committed array reads 0 for every rd_sel.
- Back-to-back captures, at the 3072 ns cadence the DES bench uses (6 ns period): first stream all-zeros, then all-ones. After the second done, every rd_sel gives FFFFFFFF. ack in between clears done for one cycle.
- LEAD=2: drive two garbage bits (1,1) followed by the stream from the first scenario. Captured words match that scenario exactly; done comes 2 cycles later.
- ack coincident with the completion edge leaves done=1; ack on the following cycle clears it.
